// File: rtl/bcd_field_counter.sv
// BCD field counter for clock/calendar fields: counts carry ticks in run mode,
// steps with auto-repeat from buttons in set mode, supports a runtime upper bound and a direct load.
module bcd_field_counter #(
    parameter int DIGITS      = 2,
    parameter int MIN_VAL     = 1,
    parameter int MAX_VAL     = 12,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_mode,
    input  logic                  tick_in,
    input  logic                  up,
    input  logic                  down,
    input  logic                  max_dyn_en,
    input  logic [4*DIGITS-1:0]   max_dyn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  tick_out,
    output logic                  load_err
);

    localparam int W       = 4 * DIGITS;
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX);

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      prev_q, prev_d;
    logic            armed_q, armed_d;
    logic [W-1:0]    value_q, value_d;
    logic            tick_q, tick_d;
    logic            err_q, err_d;

    logic [W-1:0]    eff_max, inc_val, dec_val;
    logic            wraps, step;
    logic [1:0]      dir;

    always_comb begin
        eff_max = (max_dyn_en && max_dyn >= MIN_BCD && max_dyn <= MAX_BCD) ? max_dyn : MAX_BCD;
        wraps   = (value_q >= eff_max);
        inc_val = wraps ? MIN_BCD : bcd_inc(value_q);
        if (value_q <= MIN_BCD || value_q > eff_max) dec_val = eff_max;
        else                                         dec_val = bcd_dec(value_q);
    end

    // dir is one-hot {up, down}; 00 covers both "no button" and "both buttons".
    // armed_q blocks a step for a button still held across reset until it is released.
    always_comb begin
        dir     = {up & ~down, down & ~up};
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = dir;
        armed_d = armed_q | ~(up | down);
        step    = 1'b0;
        if (run_mode) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            prev_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dir != 2'b00 && dir != prev_q && armed_q) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dir != prev_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(REPEAT_DLY - 1)) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REPEAT: begin
                    if (dir != prev_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(REPEAT_RATE - 1)) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        value_d = value_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (!bcd_valid(load_val))   err_d   = 1'b1;
            else if (load_val < MIN_BCD) value_d = MIN_BCD;
            else if (load_val > eff_max) value_d = eff_max;
            else                         value_d = load_val;
        end else if (run_mode && tick_in) begin
            value_d = inc_val;
            tick_d  = wraps;
        end else if (!run_mode && step) begin
            value_d = dir[1] ? inc_val : dec_val;
        end else if (value_q > eff_max) begin
            value_d = eff_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
            value_q <= MIN_BCD;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            value_q <= value_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign value    = value_q;
    assign tick_out = tick_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed bench for bcd_field_counter (DIGITS=2, MIN=1, MAX=12, repeat delay 4, rate 2).
module tb_bcd_field_counter;

    logic       clk = 1'b0;
    logic       rst, run_mode, tick_in, up, down, max_dyn_en, load;
    logic [7:0] max_dyn, load_val, value;
    logic       tick_out, load_err;

    int vectors = 0;
    int miscompares = 0;

    bcd_field_counter #(
        .DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .REPEAT_DLY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .run_mode(run_mode), .tick_in(tick_in),
        .up(up), .down(down), .max_dyn_en(max_dyn_en), .max_dyn(max_dyn),
        .load(load), .load_val(load_val), .value(value),
        .tick_out(tick_out), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] rep_exp [10];
        int e;
        rep_exp = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};

        rst = 1'b1; run_mode = 1'b1; tick_in = 1'b0; up = 1'b0; down = 1'b0;
        max_dyn_en = 1'b0; max_dyn = 8'h00; load = 1'b0; load_val = 8'h00;
        cyc(); cyc();
        chk("reset_value", value, 8'h01);
        chk("reset_tick", {7'd0, tick_out}, 8'h00);
        chk("reset_err", {7'd0, load_err}, 8'h00);
        rst = 1'b0;
        cyc();

        // run mode: 12 ticks walk 01..12 and wrap to 01
        for (int i = 1; i <= 12; i++) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            e = (i == 12) ? 1 : i + 1;
            chk("run_value", value, {4'(e / 10), 4'(e % 10)});
            chk("run_tick", {7'd0, tick_out}, (i == 12) ? 8'h01 : 8'h00);
            cyc();
            chk("run_tick_idle", {7'd0, tick_out}, 8'h00);
        end

        // dynamic bound below current value clamps, then tick wraps
        do_load(8'h12);
        chk("load_12", value, 8'h12);
        max_dyn_en = 1'b1; max_dyn = 8'h09;
        cyc();
        chk("dyn_clamp", value, 8'h09);
        chk("dyn_clamp_tick", {7'd0, tick_out}, 8'h00);
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("dyn_wrap", value, 8'h01);
        chk("dyn_wrap_tick", {7'd0, tick_out}, 8'h01);
        max_dyn = 8'h13;    // out of range: static MAX applies
        do_load(8'h11);
        chk("dyn_invalid_bound", value, 8'h11);
        max_dyn_en = 1'b0;

        // set mode: down from MIN wraps to MAX, both buttons do nothing
        run_mode = 1'b0;
        do_load(8'h01);
        cyc();
        down = 1'b1;
        cyc();
        chk("down_wrap", value, 8'h12);
        chk("down_wrap_tick", {7'd0, tick_out}, 8'h00);
        down = 1'b0;
        cyc();
        chk("down_release", value, 8'h12);
        up = 1'b1; down = 1'b1;
        cyc(); cyc(); cyc();
        chk("both_buttons", value, 8'h12);
        up = 1'b0; down = 1'b0;
        cyc();

        // auto-repeat: steps at cycles 1, 5, 7, 9
        do_load(8'h01);
        cyc();
        up = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("repeat_value", value, rep_exp[c]);
        end
        up = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("repeat_release", value, 8'h05);

        // loads: bad BCD, saturate high, saturate low
        do_load(8'h1A);
        chk("load_bad_value", value, 8'h05);
        chk("load_bad_err", {7'd0, load_err}, 8'h01);
        cyc();
        chk("load_err_pulse", {7'd0, load_err}, 8'h00);
        do_load(8'h15);
        chk("load_sat_hi", value, 8'h12);
        chk("load_sat_hi_err", {7'd0, load_err}, 8'h00);
        do_load(8'h00);
        chk("load_sat_lo", value, 8'h01);

        // reset during REPEAT with up still held
        cyc();
        up = 1'b1;
        for (int c = 0; c < 6; c++) cyc();
        chk("pre_reset", value, 8'h03);
        rst = 1'b1;
        #2;
        chk("async_reset", value, 8'h01);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("held_after_reset", value, 8'h01);
        up = 1'b0;
        cyc();
        chk("release_after_reset", value, 8'h01);
        up = 1'b1;
        cyc();
        chk("fresh_press", value, 8'h02);
        up = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
